// File: rtl/div_unit.sv
// Iterative 32-bit integer divider: signed/unsigned quotient and remainder,
// one restoring-division step per cycle, fixed 33-cycle latency.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic [1:0]  Div_Operation_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    output logic        Busy_o,
    output logic        Done_o,
    output logic [31:0] Result_o,
    output logic        Div_By_Zero_o
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [5:0]          count;
    logic                accept;

    // Captured operation attributes
    logic                op_rem;
    logic                a_neg;
    logic                b_neg;
    logic                b_zero;

    // Restoring-division working registers
    logic [DATA_W:0]     part_rem;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   divisor;

    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   trial;
    logic                fits;
    logic [DATA_W-1:0]   final_result;

    // Absolute value of a two's complement operand; 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(
        input logic signed [DATA_W-1:0] value,
        input logic                     as_signed
    );
        logic [DATA_W-1:0] mag;
        mag = value;
        if (as_signed && value < 0) begin
            mag = ~value + 32'd1;
        end
        return mag;
    endfunction

    // Conditional two's complement negation used to restore result signs.
    function automatic logic [DATA_W-1:0] apply_sign(
        input logic [DATA_W-1:0] value,
        input logic              negate
    );
        return negate ? (~value + 32'd1) : value;
    endfunction

    assign accept = reset && Start_i && (state == IDLE || state == DONE);

    // Bring down the next dividend bit and try subtracting the divisor.
    // The partial remainder stays below the divisor, so its top bit is
    // always clear; a set top bit would still mean the divisor fits.
    assign shifted = {part_rem[DATA_W-1:0], quotient[DATA_W-1]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign fits    = part_rem[DATA_W] | ~trial[DATA_W+1];

    // Sign fix-up of the finished magnitudes; a zero divisor leaves the
    // all-ones quotient and the raw dividend untouched.
    always_comb begin
        final_result = '0;
        if (op_rem) begin
            final_result = apply_sign(part_rem[DATA_W-1:0], a_neg);
        end else begin
            final_result = apply_sign(quotient, (a_neg ^ b_neg) & ~b_zero);
        end
    end

    // Datapath: capture operands as magnitudes on acceptance, then iterate.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_rem   <= Div_Operation_i[1];
            a_neg    <= ~Div_Operation_i[0] & A_i[DATA_W-1];
            b_neg    <= ~Div_Operation_i[0] & B_i[DATA_W-1];
            b_zero   <= (B_i == '0);
            part_rem <= '0;
            quotient <= magnitude(A_i, ~Div_Operation_i[0]);
            divisor  <= magnitude(B_i, ~Div_Operation_i[0]);
        end else if (state == CALC && count != 6'd32) begin
            if (fits) begin
                part_rem <= trial[DATA_W:0];
                quotient <= {quotient[DATA_W-2:0], 1'b1};
            end else begin
                part_rem <= shifted;
                quotient <= {quotient[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            Busy_o        <= 1'b0;
            Done_o        <= 1'b0;
            Result_o      <= '0;
            Div_By_Zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start_i) begin
                        state  <= CALC;
                        count  <= '0;
                        Busy_o <= 1'b1;
                    end
                end
                CALC: begin
                    if (count == 6'd32) begin
                        state         <= DONE;
                        Result_o      <= final_result;
                        Div_By_Zero_o <= b_zero;
                        Done_o        <= 1'b1;
                        Busy_o        <= 1'b0;
                    end else begin
                        count <= count + 6'd1;
                    end
                end
                DONE: begin
                    Done_o <= 1'b0;
                    if (Start_i) begin
                        state  <= CALC;
                        count  <= '0;
                        Busy_o <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy_o <= 1'b0;
                    Done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
